// File: rtl/dmem_arbiter_2core_if.sv
// Two-core data-memory request bus: per-core level request, address, write data,
// registered read data and a combinational stall back to each core.
interface dmem_arbiter_2core_if;
    logic        c0_rd_en;
    logic        c0_wr_en;
    logic [9:0]  c0_addr;
    logic [31:0] c0_wdata;
    logic [31:0] c0_rdata;
    logic        c0_stall;
    logic        c1_rd_en;
    logic        c1_wr_en;
    logic [9:0]  c1_addr;
    logic [31:0] c1_wdata;
    logic [31:0] c1_rdata;
    logic        c1_stall;

    modport master (
        output c0_rd_en, c0_wr_en, c0_addr, c0_wdata,
        output c1_rd_en, c1_wr_en, c1_addr, c1_wdata,
        input  c0_rdata, c0_stall, c1_rdata, c1_stall
    );

    modport slave (
        input  c0_rd_en, c0_wr_en, c0_addr, c0_wdata,
        input  c1_rd_en, c1_wr_en, c1_addr, c1_wdata,
        output c0_rdata, c0_stall, c1_rdata, c1_stall
    );
endinterface

// File: rtl/dmem_arbiter_2core.sv
// Round-robin arbiter sharing one single-port 32-bit data memory between two cores.
// One transaction at a time: IDLE -> ACCESS (counted latency) -> DONE -> IDLE.
module dmem_arbiter_2core #(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MEM_WORDS  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    dmem_arbiter_2core_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [2:0] RdCntInit = 3'(RD_LATENCY - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_op_wr;
    logic [2:0]  r_cnt;
    logic [9:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic [31:0] r_mem [MEM_WORDS];

    logic        w_req0;
    logic        w_req1;
    logic        w_load;
    logic        w_commit;
    logic        w_sel;
    logic        w_sel_wr;
    logic [9:0]  w_sel_addr;
    logic [31:0] w_sel_wdata;

    assign w_req0 = bus.c0_rd_en | bus.c0_wr_en;
    assign w_req1 = bus.c1_rd_en | bus.c1_wr_en;

    // A request with both enables set is a write; the read half is dropped.
    assign w_sel_wr    = w_sel ? bus.c1_wr_en : bus.c0_wr_en;
    assign w_sel_addr  = w_sel ? bus.c1_addr  : bus.c0_addr;
    assign w_sel_wdata = w_sel ? bus.c1_wdata : bus.c0_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        w_sel       = r_grant;
        case (r_state)
            StIdle: begin
                if (w_req0 || w_req1) begin
                    w_load      = 1'b1;
                    w_state_nxt = StAccess;
                    w_sel       = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
                end
            end
            StAccess: begin
                if (r_cnt == 3'd0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= 1'b1;
            r_last_grant <= 1'b1;
            r_op_wr      <= 1'b0;
            r_cnt        <= 3'd0;
            r_addr       <= 10'd0;
            r_wdata      <= 32'd0;
            r_rdata0     <= 32'd0;
            r_rdata1     <= 32'd0;
        end else begin
            if (w_load) begin
                r_grant <= w_sel;
                r_op_wr <= w_sel_wr;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_cnt   <= w_sel_wr ? 3'd0 : RdCntInit;
            end else if (r_state == StAccess && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_commit && !r_op_wr) begin
                if (r_grant) r_rdata1 <= r_mem[r_addr];
                else         r_rdata0 <= r_mem[r_addr];
            end
            if (r_state == StDone) r_last_grant <= r_grant;
        end
    end

    // Memory has no reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && r_op_wr) r_mem[r_addr] <= r_wdata;
    end

    assign bus.c0_rdata = r_rdata0;
    assign bus.c1_rdata = r_rdata1;
    assign bus.c0_stall = w_req0 & ~((r_state == StDone) & ~r_grant);
    assign bus.c1_stall = w_req1 & ~((r_state == StDone) &  r_grant);
endmodule

// File: doc/dmem_arbiter_2core.md
DMEM_ARBITER_2CORE -- requirements
Module: dmem_arbiter_2core

Interface
REQ-001 The block SHALL have parameter RD_LATENCY, default 2, meaning cycles spent in ACCESS for a read; legal range 1..8.
REQ-002 The block SHALL have parameter MEM_WORDS, default 1024, meaning the depth of the internal 32-bit word array, addressed by a 10-bit word address.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset: synchronous, active-high; clock clk.
REQ-005 cN_rd_en  input  1  read request from core N (N=0,1), level; held until cN_stall is low at a posedge.
REQ-006 cN_wr_en  input  1  write request from core N, level; same hold rule.
REQ-007 cN_addr  input  10  word address from core N ({tag,index} of that core's L1).
REQ-008 cN_wdata  input  32  write data from core N, already byte-merged by the L1.
REQ-009 cN_rdata  output  32  read data to core N, registered.
REQ-010 cN_stall  output  1  high while core N has an uncompleted request.

Function
REQ-011 The FSM SHALL have states IDLE, ACCESS and DONE, plus a 1-bit grant register, a 1-bit last_grant register, a 3-bit latency counter, and latched op/addr/wdata registers.
REQ-012 In IDLE with no request (all four en low), the FSM SHALL stay in IDLE.
REQ-013 In IDLE with exactly one core requesting, the block SHALL grant that core.
REQ-014 In IDLE with both cores requesting, the block SHALL grant the core not equal to last_grant (round-robin).
REQ-015 On leaving IDLE, the block SHALL latch grant, op, cN_addr and cN_wdata of the granted core, and go to ACCESS.
REQ-016 On leaving IDLE, the counter SHALL load RD_LATENCY-1 for a read and 0 for a write.
REQ-017 If cN_rd_en and cN_wr_en are both high, the request SHALL be treated as a write; the read is dropped.
REQ-018 In ACCESS with counter != 0, the counter SHALL decrement and the FSM SHALL stay in ACCESS.
REQ-019 In ACCESS with counter == 0, the FSM SHALL go to DONE on that edge.
REQ-020 On that same edge, a write SHALL commit latched wdata to mem[latched addr].
REQ-021 On that same edge, a read SHALL load mem[latched addr] into cN_rdata of the granted core.
REQ-022 In DONE, the FSM SHALL update last_grant to grant and go to IDLE unconditionally.
REQ-023 cN_stall SHALL be combinational: (cN_rd_en | cN_wr_en) AND NOT (state==DONE AND grant==N).
REQ-024 cN_stall SHALL be high in the request cycle itself, including in IDLE before grant.
REQ-025 Read latency SHALL be request cycle T, ACCESS T+1..T+RD_LATENCY, DONE T+RD_LATENCY+1 with stall low; stall is high for RD_LATENCY+1 cycles.
REQ-026 Write latency SHALL be ACCESS at T+1 and DONE at T+2; stall is high for 2 cycles.
REQ-027 cN_rdata SHALL hold its value until the next read completion for core N; a write or a completion for the other core SHALL NOT change it.
REQ-028 Requests arriving while not in IDLE SHALL wait; they are arbitrated at the next IDLE cycle.
REQ-029 Requests are never lost while their en stays high.
REQ-030 A read following a write to the same address SHALL return the newly written data.
REQ-031 Back-to-back alternating grants SHALL give each core one access per transaction window; neither core is starved.

Reset
REQ-032 On reset, state SHALL be IDLE, grant and last_grant 1 (core 0 wins the first tie), counter 0, and c0_rdata and c1_rdata 32'h0.
REQ-033 Memory contents SHALL be unaffected by reset.
REQ-034 Reset during ACCESS SHALL abort the transaction: no memory write, no rdata update.
REQ-035 After a reset that aborts a transaction, a still-asserted request SHALL be re-arbitrated from IDLE.

Verification
REQ-036 Single write then read: c0 writes 32'hDEADBEEF to addr 10'h015 at cycle 1 (stall high 2 cycles); c0 reads 10'h015 -> c0_rdata=32'hDEADBEEF in DONE, stall high exactly 3 cycles with RD_LATENCY=2.
REQ-037 Simultaneous reads right after reset: c0 reads 10'h001, c1 reads 10'h002 -> core 0 served first, c1_stall stays high until its own DONE 4 cycles later, c0_rdata unchanged during c1's completion.
REQ-038 Fairness: both cores hold write requests continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-039 Read/write conflict: c1 asserts rd_en and wr_en together, wdata 32'h12345678 to 10'h3FF -> 2-cycle write; a later read of 10'h3FF returns 32'h12345678.
REQ-040 Reset mid-read: assert reset in the second ACCESS cycle of a c0 read -> next cycle state IDLE, c0_rdata=0; a pre-reset write to 10'h020 still reads back intact.
REQ-041 Address wrap: write then read 10'h3FF and 10'h000 -> both return their own data with no aliasing.
